thread_dmem_responder: RTL and testbench
========================================

// Module: thread_dmem_responder
// PURPOSE
// Data-memory responder for the memory stage of the barrel-threaded pipeline.
// Serves loads combinationally in the same cycle as the request and absorbs stores
// in a small in-order write buffer that retires to a per-thread-partitioned
// single-port data RAM. Store-to-load forwarding keeps results coherent.
// Raises StallM to the hazard logic when a store arrives at a full buffer.
// PARAMETERS
// ADDR_W    8   word-index bits per thread (2^ADDR_W words per thread)
// THREADS   8   hardware threads; SEL_W = $clog2(THREADS) = 3
// WB_DEPTH  4   write-buffer entries; power of two, >= 2
// PORTS
// clk        in   1       clock, all state updates on rising edge
// reset      in   1       asynchronous, active-high; clears buffer state
// MemReadM   in   1       load request this cycle
// MemWriteM  in   1       store request this cycle
// selM       in   SEL_W   thread tag of the memory-stage op
// ALUOutM    in   32      byte address; bits [ADDR_W+1:2] used, rest ignored
// WriteDataM in   32      store data
// ReadDataM  out  32      load data, combinational, valid same cycle
// StallM     out  1       store not accepted this cycle; requester holds it
// wb_count   out  $clog2(WB_DEPTH)+1  occupied buffer entries
// wb_empty   out  1       wb_count == 0
// BEHAVIOUR
// - Physical index idx = {selM, ALUOutM[ADDR_W+1:2]}; RAM = THREADS*2^ADDR_W words.
//   Address bits [1:0] and above ADDR_W+1 ignored; threads fully isolated.
// - Reset (async): head=tail=0, count=0, all entry valid bits 0. StallM=0,
//   wb_empty=1, wb_count=0. RAM contents NOT reset. Reset mid-operation discards
//   pending (undrained) stores; already-drained RAM data is retained.
// - Load: ReadDataM = data of youngest valid buffer entry with matching idx, else
//   ram[idx]. Purely combinational. When MemReadM=0 ReadDataM is don't-care
//   (implementation drives the same mux; bench must not check it).
// - Store accept: MemWriteM & (count < WB_DEPTH) -> push {idx, data} at tail,
//   tail <= tail+1 mod WB_DEPTH. No coalescing; duplicates to same idx kept in order.
// - StallM = MemWriteM & (count == WB_DEPTH); combinational; store not pushed.
// - Drain (RAM write of head entry, head <= head+1 mod WB_DEPTH) fires when
//   count>0 & !MemReadM & (!MemWriteM | count==WB_DEPTH). Loads own the RAM port;
//   stores drain only in idle cycles or forced when full.
// - Push and drain same cycle only arises never (full blocks push); count updates
//   +1 push, -1 drain, at most one per cycle. Count never exceeds WB_DEPTH.
// - MemReadM & MemWriteM both 1 is illegal from the pipeline; treated as store
//   (push rules apply, no drain since MemReadM=1), ReadDataM still forwarded.
// - Drained entry is no longer forwardable; RAM read in a later cycle returns it.
// - Latency: load 0 cycles; store visible to loads the cycle after acceptance.
// TESTING
// 1. reset; store t0 addr 0x10 data 0xDEADBEEF; next cycle load t0 0x10 ->
//    ReadDataM=0xDEADBEEF, wb_count=1 (forwarded, no drain on load cycle).
// 2. RAM preloaded 0; store t1 0x10 0x11111111; load t2 0x10 -> 0x00000000;
//    load t1 0x10 -> 0x11111111 (thread isolation).
// 3. 4 back-to-back stores -> wb_count=4; 5th store -> StallM=1, head drains,
//    wb_count=3 then store accepted next cycle, StallM=0, wb_count=4.
// 4. store t0 0x20 0xA, store t0 0x20 0xB, load -> 0xB; 2 idle cycles ->
//    wb_empty=1; load t0 0x20 -> 0xB from RAM (in-order drain).
// 5. 3 pending stores, assert reset mid-cycle (async) -> wb_count=0, StallM=0
//    immediately; loads of those addresses return pre-store RAM values.
// 6. 10 alternating store/idle pairs to distinct addrs -> pointers wrap twice;
//    each load afterwards returns its own data; wb_count never exceeds 1.

Source files
------------

// File: rtl/thread_dmem_if.sv
// Memory-stage bus between the pipeline and the thread data-memory responder.
// Loads return combinationally; StallM tells the pipeline to hold a store.
interface thread_dmem_if #(
  parameter int ADDR_W   = 8,
  parameter int THREADS  = 8,
  parameter int WB_DEPTH = 4
);
  localparam int SEL_W = $clog2(THREADS);
  localparam int CNT_W = $clog2(WB_DEPTH) + 1;

  logic             MemReadM;
  logic             MemWriteM;
  logic [SEL_W-1:0] selM;
  logic [31:0]      ALUOutM;
  logic [31:0]      WriteDataM;
  logic [31:0]      ReadDataM;
  logic             StallM;
  logic [CNT_W-1:0] wb_count;
  logic             wb_empty;

  modport master (
    output MemReadM, MemWriteM, selM, ALUOutM, WriteDataM,
    input  ReadDataM, StallM, wb_count, wb_empty
  );

  modport slave (
    input  MemReadM, MemWriteM, selM, ALUOutM, WriteDataM,
    output ReadDataM, StallM, wb_count, wb_empty
  );
endinterface

// File: rtl/thread_dmem_responder.sv
// Per-thread partitioned data RAM with an in-order store buffer. Loads own the
// RAM port and see buffered stores through youngest-match forwarding.
module thread_dmem_responder #(
  parameter int ADDR_W   = 8,
  parameter int THREADS  = 8,
  parameter int WB_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  thread_dmem_if.slave bus
);
  localparam int SEL_W = $clog2(THREADS);
  localparam int IDX_W = SEL_W + ADDR_W;
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WORDS = THREADS << ADDR_W;

  logic [31:0]         ram     [WORDS];
  logic [IDX_W-1:0]    entIdx  [WB_DEPTH];
  logic [31:0]         entData [WB_DEPTH];
  logic [WB_DEPTH-1:0] entVld;
  logic [WB_DEPTH-1:0] hit;
  logic [PTR_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;
  logic [IDX_W-1:0]    idx;
  logic [31:0]         rdData;
  logic                full, push, drain;
  logic                unusedAddr;

  // Thread tag forms the upper index bits, so threads can never alias.
  assign idx        = {bus.selM, bus.ALUOutM[ADDR_W+1:2]};
  assign unusedAddr = ^{bus.ALUOutM[31:ADDR_W+2], bus.ALUOutM[1:0]};

  assign full  = (count == CNT_W'(WB_DEPTH));
  assign push  = bus.MemWriteM & ~full;
  assign drain = (count != '0) & ~bus.MemReadM & (~bus.MemWriteM | full);

  for (genvar e = 0; e < WB_DEPTH; e++) begin : g_hit
    assign hit[e] = entVld[e] && (entIdx[e] == idx);
  end

  // Walk oldest to youngest so the last matching entry wins.
  always_comb begin : forward
    logic [PTR_W-1:0] pos;
    pos    = '0;
    rdData = ram[idx];
    for (int k = 0; k < WB_DEPTH; k++) begin
      pos = head + PTR_W'(k);
      if (hit[pos]) rdData = entData[pos];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      entVld <= '0;
    end else begin
      if (push) begin
        entVld[tail] <= 1'b1;
        tail         <= tail + 1'b1;
        count        <= count + 1'b1;
      end else if (drain) begin
        entVld[head] <= 1'b0;
        head         <= head + 1'b1;
        count        <= count - 1'b1;
      end
    end
  end

  // Payload needs no reset: an entry is only observed while its valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      entIdx[tail]  <= idx;
      entData[tail] <= bus.WriteDataM;
    end
  end

  always_ff @(posedge clk) begin
    if (drain) ram[entIdx[head]] <= entData[head];
  end

  assign bus.ReadDataM = rdData;
  assign bus.StallM    = bus.MemWriteM & full;
  assign bus.wb_count  = count;
  assign bus.wb_empty  = (count == '0);
endmodule

// File: tb/tb_thread_dmem_responder.sv
// Scenario bench for thread_dmem_responder: loads push their architectural
// expectation into a queue and pop it when the combinational result is sampled.
module tb_thread_dmem_responder;
  localparam int ADDR_W = 8, THREADS = 8, WB_DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  thread_dmem_if #(.ADDR_W(ADDR_W), .THREADS(THREADS), .WB_DEPTH(WB_DEPTH)) dmem ();

  thread_dmem_responder #(.ADDR_W(ADDR_W), .THREADS(THREADS), .WB_DEPTH(WB_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dmem)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] expQ  [$];
  logic [31:0] model [int];

  function automatic int idxOf(input int sel, input logic [31:0] addr);
    return sel * (1 << ADDR_W) + int'(addr[ADDR_W+1:2]);
  endfunction

  // Drive one cycle of stimulus and stop at the following negedge for sampling.
  task automatic step(input logic rd, input logic wr, input int sel,
                      input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    dmem.MemReadM   = rd;
    dmem.MemWriteM  = wr;
    dmem.selM       = 3'(sel);
    dmem.ALUOutM    = addr;
    dmem.WriteDataM = data;
    if (rd) expQ.push_back(model[idxOf(sel, addr)]);
    if (wr) model[idxOf(sel, addr)] = data;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 32'h0, 32'h0);
  endtask

  task automatic drainAll(input string name);
    for (int n = 0; n < 20 && !dmem.wb_empty; n++) idle();
    checks++;
    if (dmem.wb_empty !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain: wb_count=%0d never reached 0", name, dmem.wb_count);
    end
  endtask

  task automatic test_reset();
    logic [31:0] unusedVal;
    dmem.MemReadM = 1'b0; dmem.MemWriteM = 1'b1; dmem.selM = '0;
    dmem.ALUOutM = '0; dmem.WriteDataM = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dmem.wb_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", dmem.wb_count); end
    checks++;
    if (dmem.wb_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", dmem.wb_empty); end
    checks++;
    if (dmem.StallM !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", dmem.StallM); end
    dmem.MemWriteM = 1'b0;
    reset = 1'b0;
    unusedVal = '0;
    expQ.delete();
    if (unusedVal != 0) $display("unexpected");
  endtask

  task automatic test_forward();
    logic [31:0] exp;
    step(1'b0, 1'b1, 0, 32'h10, 32'hDEADBEEF);
    step(1'b1, 1'b0, 0, 32'h10, 32'h0);
    exp = expQ.pop_front();
    checks++;
    if (dmem.ReadDataM !== exp) begin errors++; $display("FAIL fwd_data: got %h want %h", dmem.ReadDataM, exp); end
    checks++;
    if (dmem.wb_count !== 3'd1) begin errors++; $display("FAIL fwd_count: got %0d want 1", dmem.wb_count); end
    drainAll("fwd");
  endtask

  task automatic test_isolation();
    logic [31:0] exp;
    step(1'b0, 1'b1, 2, 32'h10, 32'h0);   // known zero for thread 2
    drainAll("iso_pre");
    step(1'b0, 1'b1, 1, 32'h10, 32'h11111111);
    step(1'b1, 1'b0, 2, 32'h10, 32'h0);
    exp = expQ.pop_front();
    checks++;
    if (dmem.ReadDataM !== exp) begin errors++; $display("FAIL iso_t2: got %h want %h", dmem.ReadDataM, exp); end
    step(1'b1, 1'b0, 1, 32'h10, 32'h0);
    exp = expQ.pop_front();
    checks++;
    if (dmem.ReadDataM !== exp) begin errors++; $display("FAIL iso_t1: got %h want %h", dmem.ReadDataM, exp); end
    drainAll("iso");
  endtask

  task automatic test_full_stall();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3, 32'(i * 4), 32'hA000_0000 + 32'(i));
    step(1'b0, 1'b1, 3, 32'h10, 32'hA000_0004);
    checks++;
    if (dmem.wb_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", dmem.wb_count); end
    checks++;
    if (dmem.StallM !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", dmem.StallM); end
    step(1'b0, 1'b1, 3, 32'h10, 32'hA000_0004);
    checks++;
    if (dmem.StallM !== 1'b0) begin errors++; $display("FAIL full_accept: StallM got %b want 0", dmem.StallM); end
    checks++;
    if (dmem.wb_count !== 3'd3) begin errors++; $display("FAIL full_drained: got %0d want 3", dmem.wb_count); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 3, 32'(i * 4), 32'h0);
      exp = expQ.pop_front();
      checks++;
      if (dmem.ReadDataM !== exp) begin errors++; $display("FAIL full_load%0d: got %h want %h", i, dmem.ReadDataM, exp); end
    end
    checks++;
    if (dmem.wb_count !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d want 4", dmem.wb_count); end
    drainAll("full");
  endtask

  task automatic test_in_order();
    logic [31:0] exp;
    step(1'b0, 1'b1, 0, 32'h20, 32'hA);
    step(1'b0, 1'b1, 0, 32'h20, 32'hB);
    step(1'b1, 1'b0, 0, 32'h20, 32'h0);
    exp = expQ.pop_front();
    checks++;
    if (dmem.ReadDataM !== exp) begin errors++; $display("FAIL order_fwd: got %h want %h", dmem.ReadDataM, exp); end
    idle();
    idle();
    step(1'b1, 1'b0, 0, 32'h20, 32'h0);
    exp = expQ.pop_front();
    checks++;
    if (dmem.wb_empty !== 1'b1) begin errors++; $display("FAIL order_empty: got %b want 1", dmem.wb_empty); end
    checks++;
    if (dmem.ReadDataM !== exp) begin errors++; $display("FAIL order_ram: got %h want %h", dmem.ReadDataM, exp); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    logic [31:0] saved [3];
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4, 32'(i * 4), 32'h5000 + 32'(i));
    drainAll("rmid_pre");
    for (int i = 0; i < 3; i++) saved[i] = model[idxOf(4, 32'(i * 4))];
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4, 32'(i * 4), 32'h9999_0000 + 32'(i));
    @(posedge clk); #1;
    dmem.MemWriteM = 1'b1;
    dmem.ALUOutM   = 32'h40;
    checks++;
    if (dmem.wb_count !== 3'd3) begin errors++; $display("FAIL rmid_pending: got %0d want 3", dmem.wb_count); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dmem.wb_count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", dmem.wb_count); end
    checks++;
    if (dmem.StallM !== 1'b0) begin errors++; $display("FAIL rmid_stall: got %b want 0", dmem.StallM); end
    dmem.MemWriteM = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    // Pending stores were discarded, so the architectural view reverts.
    for (int i = 0; i < 3; i++) model[idxOf(4, 32'(i * 4))] = saved[i];
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4, 32'(i * 4), 32'h0);
      exp = expQ.pop_front();
      checks++;
      if (dmem.ReadDataM !== exp) begin errors++; $display("FAIL rmid_load%0d: got %h want %h", i, dmem.ReadDataM, exp); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    int          maxCnt;
    maxCnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 5, 32'(i * 4), $urandom);
      if (int'(dmem.wb_count) > maxCnt) maxCnt = int'(dmem.wb_count);
      idle();
      if (int'(dmem.wb_count) > maxCnt) maxCnt = int'(dmem.wb_count);
    end
    checks++;
    if (maxCnt > 1) begin errors++; $display("FAIL wrap_maxcount: got %0d want <=1", maxCnt); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 5, 32'(i * 4), 32'h0);
      exp = expQ.pop_front();
      checks++;
      if (dmem.ReadDataM !== exp) begin errors++; $display("FAIL wrap_load%0d: got %h want %h", i, dmem.ReadDataM, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_isolation();
    test_full_stall();
    test_in_order();
    test_reset_mid();
    test_wrap();
    checks++;
    if (expQ.size() != 0) begin errors++; $display("FAIL scoreboard_left: %0d entries unconsumed", expQ.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
